// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit layout, constants and flit builders
package noc_pkg;
  localparam int FLIT_W    = 35;
  localparam int DATA_W    = 32;
  localparam int COORD_W   = 2;
  localparam int VC_NUM    = 2;
  localparam int HEAD_BIT  = 34;
  localparam int TAIL_BIT  = 33;
  localparam int DST_X_LSB = 31;
  localparam int DST_Y_LSB = 29;
  localparam int SRC_X_LSB = 27;
  localparam int SRC_Y_LSB = 25;

  typedef logic [FLIT_W-1:0]  flit_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } tx_state_t;

  function automatic flit_t make_head(coord_t dx, coord_t dy, coord_t sx, coord_t sy);
    flit_t f;
    f = '0;
    f[HEAD_BIT] = 1'b1;
    f[DST_X_LSB +: COORD_W] = dx;
    f[DST_Y_LSB +: COORD_W] = dy;
    f[SRC_X_LSB +: COORD_W] = sx;
    f[SRC_Y_LSB +: COORD_W] = sy;
    return f;
  endfunction

  // Bit 32 stays zero so body flits never alias the destination field.
  function automatic flit_t make_body(logic last, logic [DATA_W-1:0] data);
    flit_t f;
    f = '0;
    f[TAIL_BIT] = last;
    f[DATA_W-1:0] = data;
    return f;
  endfunction
endpackage

// File: rtl/noc_credit_cnt.sv
// rtl/noc_credit_cnt.sv - per-VC downstream buffer credit counter with sticky overflow flag
module noc_credit_cnt #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic err
);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= FULL;
      err   <= 1'b0;
    end else if (inc && !dec) begin
      // A return beyond the buffer depth means the router acked a flit we never sent.
      if (count == FULL) err <= 1'b1;
      else               count <= count + CW'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign nonzero = (count != '0);
endmodule

// File: rtl/noc_ni_tx.sv
// rtl/noc_ni_tx.sv - NI transmitter: word stream to credit-gated flits; NOC_NI_TX_STATS_EN adds counters
module noc_ni_tx
  import noc_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CW      = 3,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  input  logic              in_vc,
  input  logic [1:0]        in_dst_x,
  input  logic [1:0]        in_dst_y,
  output logic [34:0]       ODATA,
  output logic              OVALID,
  output logic              OVCH,
  input  logic [1:0]        IACK,
  input  logic [1:0]        ILCK,
  output logic              credit_err
`ifdef NOC_NI_TX_STATS_EN
  ,
  output logic [15:0]       stat_flits,
  output logic [15:0]       stat_stall
`endif
);
  localparam coord_t SRC_X = COORD_W'(MY_X);
  localparam coord_t SRC_Y = COORD_W'(MY_Y);

  tx_state_t         state, state_nx;
  logic              vc_q;
  logic              issue;
  logic              issue_vc;
  logic              latch_vc;
  flit_t             flit_nx;
  logic [VC_NUM-1:0] nz;
  logic [VC_NUM-1:0] dec;
  logic [VC_NUM-1:0] err_v;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // in_ready depends only on state and registered credits, never on IACK/ILCK directly.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    issue    = 1'b0;
    issue_vc = vc_q;
    latch_vc = 1'b0;
    flit_nx  = make_body(in_last, in_data);
    dec      = '0;
    case (state)
      ST_IDLE: begin
        if (in_valid && nz[in_vc] && !ILCK[in_vc]) begin
          issue    = 1'b1;
          issue_vc = in_vc;
          latch_vc = 1'b1;
          flit_nx  = make_head(in_dst_x, in_dst_y, SRC_X, SRC_Y);
          state_nx = ST_BODY;
        end
      end
      ST_BODY: begin
        in_ready = nz[vc_q];
        if (in_valid && nz[vc_q]) begin
          issue = 1'b1;
          if (in_last) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (issue) dec[issue_vc] = 1'b1;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ODATA  <= '0;
      OVALID <= 1'b0;
      OVCH   <= 1'b0;
      vc_q   <= 1'b0;
    end else begin
      OVALID <= issue;
      if (issue) begin
        ODATA <= flit_nx;
        OVCH  <= issue_vc;
      end
      if (latch_vc) vc_q <= in_vc;
    end
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : g_cc
    noc_credit_cnt #(
      .CREDITS (CREDITS),
      .CW      (CW)
    ) u_cc (
      .clk     (clk),
      .rst     (RST),
      .inc     (IACK[v]),
      .dec     (dec[v]),
      .nonzero (nz[v]),
      .err     (err_v[v])
    );
  end

  assign credit_err = |err_v;

`ifdef NOC_NI_TX_STATS_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      if (OVALID && stat_flits != 16'hFFFF) stat_flits <= stat_flits + 16'd1;
      if (in_valid && !issue && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif
endmodule

// File: doc/noc_ni_tx.md
Name: noc_ni_tx

Overview:
- Network-interface transmitter. Converts a local word stream into head/body/tail flits and drives one router input port (the router's IDATA/IVALID/IVCH side).
- Tracks per-VC credits returned by the router's ack lines. Never sends a flit into a VC with no free downstream buffer.
- Sits between a tile's core and the router's local port (port 4) in the mesh.

Parameters:
- CREDITS, 4, initial and maximum credit count per VC (router input buffer depth).
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS.
- MY_X, 0, source X coordinate inserted in head flits (2 bits).
- MY_Y, 0, source Y coordinate inserted in head flits (2 bits).

Ports:
- clk  in  1  clock
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  local word valid
- in_ready  out  1  local word accepted when in_valid & in_ready
- in_data  in  32  payload word
- in_last  in  1  final word of packet
- in_vc  in  1  VC for packet; sampled only at packet start
- in_dst_x  in  2  destination X; sampled at packet start
- in_dst_y  in  2  destination Y; sampled at packet start
- ODATA  out  35  flit to router
- OVALID  out  1  flit valid, one cycle per flit
- OVCH  out  1  VC of flit on ODATA
- IACK  in  2  per-VC credit return pulse from router; bit v = VC v
- ILCK  in  2  per-VC lock from router; 1 = VC held by another packet
- credit_err  out  1  sticky: ack received while that VC's credit already at CREDITS

Behaviour:
- Reset values: in_ready=0, ODATA=0, OVALID=0, OVCH=0, credit_err=0, both credit counters=CREDITS, state=IDLE. Reset mid-packet aborts the packet: no tail is sent and no credits are restored beyond the reset value.
- Flit format, bit 34 = MSB:
  - [34] head flag, [33] tail flag.
  - Head flit payload: [32:31] dst_x, [30:29] dst_y, [28:27] MY_X, [26:25] MY_Y, [24:0]=0.
  - Body/tail flit payload: [32]=0, [31:0] in_data.
- State IDLE:
  - in_ready=0.
  - If in_valid & credit[in_vc]!=0 & ILCK[in_vc]==0: register head flit (head=1, tail=0) with OVALID=1 and OVCH=in_vc on the next edge. Latch vc, dst_x, dst_y. Decrement credit[in_vc]. Go to BODY.
  - The triggering word is not consumed; in_data is ignored in this cycle.
- State BODY:
  - in_ready = (credit[vc_q]!=0). Combinational from the registered count only, never from IACK.
  - On accept: register flit (head=0, tail=in_last, payload=in_data), OVALID=1, OVCH=vc_q, decrement credit[vc_q].
  - If in_last: go to IDLE. in_vc and dst inputs are ignored while in BODY.
- OVALID is 0 in every cycle without a registered issue. There are no bubbles requirements beyond credits: back-to-back flits are allowed every cycle.
- Latency: 1 cycle from accept (or head decision) to flit on ODATA. A packet of N words produces N+1 flits. Minimum one IDLE cycle between packets, so a packet's head appears no earlier than 1 cycle after the previous tail.
- Credits:
  - credit[v] += IACK[v]; credit[v] -= issue on v.
  - Issue and ack on the same VC in the same cycle: count unchanged.
  - Ack when count==CREDITS and no issue: count stays CREDITS, credit_err set (cleared only by RST).
  - Count never goes below 0; issue is gated by count!=0.
- ILCK is checked only at head time. A lock rising mid-packet does not stall the body.
- No combinational path from IACK/ILCK to ODATA/OVALID. The path from ILCK/credits to in_ready exists only through registered state.

Optional Feature:
- NOC_NI_TX_STATS_EN defined: adds outputs stat_flits (16 bits) and stat_stall (16 bits).
  - stat_flits counts every OVALID cycle.
  - stat_stall counts cycles where in_valid=1 but no flit could be issued (credit zero or lock).
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package noc_pkg: FLIT_W=35, bit index constants HEAD_BIT/TAIL_BIT, head field offsets, VC_NUM=2, coordinate width 2. The future noc_ni_rx uses the same package.
- Sub-module noc_credit_cnt: one per VC, with inputs inc/dec, output nonzero, err flag, parameters CREDITS/CW.

Test Plan:
- Reset, then a 3-word packet (vc=0, dst=(2,1), words A,B,C), MY=(1,0), IACK idle -> 4 consecutive flits:
  - ODATA head with [32:25]=8'b10_01_01_00.
  - Then A, B, C, with tail only on C; OVCH=0 throughout.
  - credit[0] ends at 0.
- CREDITS=4, 6-word packet on vc=1, no acks -> head plus 3 bodies, then in_ready=0. Pulse IACK[1] twice -> exactly 2 more flits, each 1 cycle after its ack.
- credit[0]=1; same cycle: issue on vc0 and IACK[0]=1 -> count stays 1 and the next word issues without a stall.
- ILCK[1]=1 while in_valid with in_vc=1 in IDLE -> no OVALID for 5 cycles; ILCK drops -> head on the next edge.
- IACK[0] pulse with credit[0]=4 -> credit_err=1 and remains 1 after 10 idle cycles.
- Assert RST mid-packet after 2 flits -> OVALID=0 and in_ready=0 immediately; credits=4 after release. A new packet starts with a head flit.
